muldiv_sequencer: RTL and testbench

Multi-cycle sequencer that runs RV32M-style MUL, DIVU and REMU on the existing shared ALU rather than dedicated multiplier/divider hardware. It sits beside the execute stage. It drives the ALU operand and control inputs one micro-operation per cycle and reads back `result`/`branch_taken`. It then returns a single 32-bit result through a start/done handshake.

---
 rtl/muldiv_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared execute-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: shorter MUL when the multiplier runs out, and fast divide-by-zero.
module muldiv_sequencer #(
  parameter int unsigned LENGTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LENGTH-1:0] operand_a,
  input  logic [LENGTH-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] result,
  output logic [LENGTH-1:0] alu_a,
  output logic [LENGTH-1:0] alu_b,
  output logic [4:0]        alu_control,
  input  logic [LENGTH-1:0] alu_result,
  input  logic              alu_branch_taken
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_STEP = 3'd1;
  localparam logic [2:0] S_DIV_CMP  = 3'd2;
  localparam logic [2:0] S_DIV_SUB  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;
  localparam logic [4:0] ALU_GEU = 5'b10111;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [4:0] LAST = 5'(LENGTH - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [LENGTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [LENGTH:0]   rem_q, rem_d;
  logic [LENGTH-1:0] quo_q, quo_d, divisor_q, divisor_d;
  logic              ge_q, ge_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [LENGTH-1:0] result_q, result_d;
  logic [LENGTH:0]   rem_sub;
  logic [LENGTH-1:0] quo_sub;
  logic              accept;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // ALU drive is a pure decode of registered state, so it settles right after each edge.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    case (state_q)
      S_MUL_STEP: begin
        alu_a = acc_q;
        alu_b = mplier_q[0] ? mcand_q : '0;
      end
      S_DIV_CMP: begin
        alu_a       = rem_q[LENGTH-1:0];
        alu_b       = divisor_q;
        alu_control = ALU_GEU;
      end
      S_DIV_SUB: begin
        alu_a       = rem_q[LENGTH-1:0];
        alu_b       = divisor_q;
        alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    ge_d      = ge_q;
    result_d  = result_q;
    done_d    = 1'b0;
    accept    = start && !busy_q && !flush;
    rem_sub   = ge_q ? {1'b0, alu_result} : rem_q;
    quo_sub   = ge_q ? {quo_q[LENGTH-1:1], 1'b1} : quo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = operand_a;
          mplier_d  = operand_b;
          divisor_d = operand_b;
          // First restoring-division shift is folded into the accept cycle.
          rem_d     = {{LENGTH{1'b0}}, operand_a[LENGTH-1]};
          quo_d     = {operand_a[LENGTH-2:0], 1'b0};
          case (op)
            OP_MUL:           state_d = S_MUL_STEP;
            OP_DIVU, OP_REMU: state_d = S_DIV_CMP;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_MUL_STEP: begin
        acc_d    = alu_result;
        mcand_d  = {mcand_q[LENGTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[LENGTH-1:1]};
        cnt_d    = cnt_q + 5'd1;
`ifdef MULDIV_EARLY_OUT_EN
        if (cnt_q == LAST || mplier_q[LENGTH-1:1] == '0) state_d = S_DONE;
`else
        if (cnt_q == LAST) state_d = S_DONE;
`endif
      end
      S_DIV_CMP: begin
        ge_d    = rem_q[LENGTH] | alu_branch_taken;
        state_d = S_DIV_SUB;
`ifdef MULDIV_EARLY_OUT_EN
        if (divisor_q == '0) begin
          // Undo the entry shift to recover the dividend as the remainder.
          quo_d   = '1;
          rem_d   = {1'b0, rem_q[0], quo_q[LENGTH-1:1]};
          state_d = S_DONE;
        end
`endif
      end
      S_DIV_SUB: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          rem_d   = rem_sub;
          quo_d   = quo_sub;
          state_d = S_DONE;
        end else begin
          rem_d   = {rem_sub[LENGTH-1:0], quo_sub[LENGTH-1]};
          quo_d   = {quo_sub[LENGTH-2:0], 1'b0};
          state_d = S_DIV_CMP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MUL:  result_d = acc_q;
          OP_DIVU: result_d = quo_q;
          OP_REMU: result_d = rem_q[LENGTH-1:0];
          default: result_d = '0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end

    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      ge_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      ge_q      <= ge_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural model of the shared ALU.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [4:0]  alu_control;
  logic        alu_branch_taken;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.LENGTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_branch_taken(alu_branch_taken)
  );

  // Shared ALU: add, subtract, unsigned >= branch compare.
  always_comb begin
    alu_result       = '0;
    alu_branch_taken = 1'b0;
    case (alu_control)
      5'b00000: alu_result = alu_a + alu_b;
      5'b01000: alu_result = alu_a - alu_b;
      5'b10111: alu_branch_taken = (alu_a >= alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int unsigned lat_fix;
    int unsigned lat_eo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", nm, id, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int id);
    chk("rst_busy", id, {31'b0, busy}, 32'd0);
    chk("rst_done", id, {31'b0, done}, 32'd0);
    chk("rst_result", id, result, 32'd0);
    chk("rst_alu_a", id, alu_a, 32'd0);
    chk("rst_alu_b", id, alu_b, 32'd0);
    chk("rst_alu_ctl", id, {27'b0, alu_control}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int unsigned exp_lat, input int id);
    int unsigned cyc;
    logic        got;
    issue(o, a, b);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", id, {31'b0, got}, 32'd1);
    chk("result", id, result, exp_r);
    chk("latency", id, cyc, exp_lat);
    chk("busy_at_done", id, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", id, {31'b0, done}, 32'd0);
    chk("busy_after", id, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned ndone, first;
    // op, a, b, expected, fixed latency, early-out latency
    vecs.push_back('{2'b00, 32'd7,          32'd6,          32'd42,         33, 4});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33, 3});
    vecs.push_back('{2'b00, 32'h1234_5678,  32'd0,          32'd0,          33, 2});
    vecs.push_back('{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          33, 18});
    vecs.push_back('{2'b00, 32'd3,          32'h8000_0000,  32'h8000_0000,  33, 33});
    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         65, 65});
    vecs.push_back('{2'b10, 32'd100,        32'd7,          32'd2,          65, 65});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          65, 65});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  65, 65});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  65, 2});
    vecs.push_back('{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678,  65, 2});
    vecs.push_back('{2'b11, 32'hAAAA_5555,  32'd9,          32'd0,          1,  1});
    vecs.push_back('{2'b10, 32'hDEAD_BEEF,  32'h10,         32'hF,          65, 65});
    vecs.push_back('{2'b01, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  65, 65});

    reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs(0);
    reset = 1'b0;

    foreach (vecs[i]) begin
`ifdef MULDIV_EARLY_OUT_EN
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat_eo, i + 1);
`else
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat_fix, i + 1);
`endif
    end

    // start pulses during a busy DIVU and during its done cycle must be dropped
    issue(2'b01, 32'd100, 32'd7);
    ndone = 0; first = 0;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (c == 5 || c == 65) begin
        start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd3;
      end
      if (c == 6 || c == 66) start = 1'b0;
    end
    chk("busy_start_ndone", 100, ndone, 32'd1);
    chk("busy_start_first", 100, first, 32'd65);
    chk("busy_start_result", 100, result, 32'd14);
    chk("busy_start_idle", 100, {31'b0, busy}, 32'd0);

    // flush at cycle 10 of a long MUL: no done, result held
    issue(2'b00, 32'd7, 32'h8000_0006);
    ndone = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (c == 10) begin
        chk("flush_busy_before", 101, {31'b0, busy}, 32'd1);
        flush = 1'b1;
      end
      if (c == 11) begin
        flush = 1'b0;
        chk("flush_idle", 101, {31'b0, busy}, 32'd0);
      end
    end
    chk("flush_ndone", 101, ndone, 32'd0);
    chk("flush_result", 101, result, 32'd14);
    run_req(2'b00, 32'd7, 32'd6, 32'd42,
`ifdef MULDIV_EARLY_OUT_EN
            4,
`else
            33,
`endif
            102);
    run_req(2'b00, 32'd7, 32'h8000_0006, 32'h8000_002A, 33, 103);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b11;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 104, {31'b0, busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("flush_start_ndone", 104, ndone, 32'd0);
    chk("flush_start_result", 104, result, 32'h8000_002A);

    // asynchronous reset mid-DIV
    issue(2'b01, 32'hDEAD_BEEF, 32'd3);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_busy", 105, {31'b0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1 chk_reset_outputs(105);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst_mid_ndone", 105, ndone, 32'd0);
    run_req(2'b10, 32'd100, 32'd7, 32'd2, 65, 106);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
